// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline sequencer port bundle: ID-stage decode and imem status in,
// stage-register enables, jump select and the stall counter out.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
);
  logic                imem_ready;
  logic                id_valid;
  logic [5:0]          id_opcode;
  logic [REG_BITS-1:0] id_rs;
  logic [REG_BITS-1:0] id_rt;
  logic                id_uses_rs;
  logic                id_uses_rt;
  logic [REG_BITS-1:0] id_dest;
  logic                id_wr_en;
  logic                pc_en;
  logic                pc_sel_jump;
  logic                if_id_en;
  logic                id_exe_en;
  logic                id_exe_bubble;
  logic                exe_mem_en;
  logic                mem_wb_en;
  logic [CNT_BITS-1:0] stall_count;

  modport master (
    output imem_ready, id_valid, id_opcode, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_dest, id_wr_en,
    input  pc_en, pc_sel_jump, if_id_en, id_exe_en, id_exe_bubble, exe_mem_en,
           mem_wb_en, stall_count
  );

  modport slave (
    input  imem_ready, id_valid, id_opcode, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_dest, id_wr_en,
    output pc_en, pc_sel_jump, if_id_en, id_exe_en, id_exe_bubble, exe_mem_en,
           mem_wb_en, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline sequencer: RAW stall via an in-flight destination
// scoreboard, wrong-path squash after jumps, and freeze on imem not ready.
module pipeline_hazard_ctrl #(
  parameter int         REG_BITS = 5,
  parameter logic [5:0] JUMP_OP  = 6'h03,
  parameter int         CNT_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

  state_t              state_reg, state_next;
  // entry 0 = EX, 1 = MEM, 2 = WB
  logic [2:0]          sb_valid_reg;
  logic [REG_BITS-1:0] sb_dest_reg [3];
  logic [CNT_BITS-1:0] stall_count_reg;

  logic [2:0] hit_rs, hit_rt;
  logic       hazard, issue, ex_valid_next;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_hit
      assign hit_rs[gi] = sb_valid_reg[gi] && (sb_dest_reg[gi] != '0) &&
                          (sb_dest_reg[gi] == bus.id_rs);
      assign hit_rt[gi] = sb_valid_reg[gi] && (sb_dest_reg[gi] != '0) &&
                          (sb_dest_reg[gi] == bus.id_rt);
    end
  endgenerate

  assign hazard = bus.id_valid && (state_reg != FLUSH) &&
                  ((bus.id_uses_rs && |hit_rs) || (bus.id_uses_rt && |hit_rt));
  assign issue  = bus.id_valid && !hazard && (state_reg != FLUSH);
  assign ex_valid_next = issue && bus.id_wr_en && (bus.id_dest != '0);

  always_comb begin
    state_next        = RUN;
    bus.pc_en         = 1'b1;
    bus.pc_sel_jump   = 1'b0;
    bus.if_id_en      = 1'b1;
    bus.id_exe_en     = 1'b1;
    bus.id_exe_bubble = !bus.id_valid;
    bus.exe_mem_en    = 1'b1;
    bus.mem_wb_en     = 1'b1;
    if (rst) begin
      bus.pc_en         = 1'b0;
      bus.if_id_en      = 1'b0;
      bus.id_exe_en     = 1'b0;
      bus.id_exe_bubble = 1'b1;
      bus.exe_mem_en    = 1'b0;
      bus.mem_wb_en     = 1'b0;
    end else if (!bus.imem_ready) begin
      state_next        = state_reg;
      bus.pc_en         = 1'b0;
      bus.if_id_en      = 1'b0;
      bus.id_exe_en     = 1'b0;
      bus.id_exe_bubble = 1'b0;
      bus.exe_mem_en    = 1'b0;
      bus.mem_wb_en     = 1'b0;
    end else if (state_reg == FLUSH) begin
      // wrong-path instruction sitting in IF/ID is replaced by a bubble
      bus.id_exe_bubble = 1'b1;
    end else if (hazard) begin
      state_next        = STALL;
      bus.pc_en         = 1'b0;
      bus.if_id_en      = 1'b0;
      bus.id_exe_bubble = 1'b1;
    end else if (bus.id_valid && bus.id_opcode == JUMP_OP) begin
      state_next        = FLUSH;
      bus.pc_sel_jump   = 1'b1;
      bus.id_exe_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      sb_valid_reg    <= '0;
      stall_count_reg <= '0;
      for (int i = 0; i < 3; i++) sb_dest_reg[i] <= '0;
    end else if (bus.imem_ready) begin
      state_reg    <= state_next;
      sb_valid_reg <= {sb_valid_reg[1:0], ex_valid_next};
      sb_dest_reg[2] <= sb_dest_reg[1];
      sb_dest_reg[1] <= sb_dest_reg[0];
      sb_dest_reg[0] <= bus.id_dest;
      if (hazard && stall_count_reg != '1)
        stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  assign bus.stall_count = stall_count_reg;
endmodule
